// File: rtl/keypad_scan_fifo_pkg.sv
// Shared constants and helpers for the scanned keypad with key queue.
package keypad_pkg;

  // Bit positions inside the status word returned when sel_status = 1
  localparam int unsigned ST_READY     = 0;
  localparam int unsigned ST_OVF       = 1;
  localparam int unsigned ST_FULL      = 2;
  localparam int unsigned ST_COUNT_LSB = 8;

  // Bits needed to hold a linear key code for a matrix of the given key count
  function automatic int unsigned code_width(input int unsigned keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

  // Printed legend of the 4x4 keypad: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [3:0] hex_legend(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// CPU-side bus of the keypad: read select, pop / clear strobes, read data and interrupt.
interface keypad_scan_fifo_if;
  logic        sel_status;
  logic        pop;
  logic        clr_ovf;
  logic [15:0] rdata;
  logic        irq;

  modport master (output sel_status, pop, clr_ovf, input  rdata, irq);
  modport slave  (input  sel_status, pop, clr_ovf, output rdata, irq);
endinterface

// File: rtl/keypad_scan_fifo_fifo.sv
// Key code queue: wrap-bit pointers, sticky overflow, pop ignored when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_ovf,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop on a full queue frees the slot the simultaneous push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and sticky overflow update; a dropped push beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !do_pop) ovf <= 1'b1;
      else if (clr_ovf)            ovf <= 1'b0;
    end
  end

  // Storage write; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keypad_scan_fifo.sv
// Row-scanned keypad: synchronise columns, debounce per row, reject multi-key, queue codes.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned DEBOUNCE   = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAP_HEX    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_drive,
  input  logic [COLS-1:0]   col_sense,
  keypad_scan_fifo_if.slave bus
);
  localparam int unsigned CW  = code_width(ROWS * COLS);
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  logic [COLS-1:0]     col_s1, col_s2;
  logic [SCAN_DIV-1:0] prescaler;
  logic [RW-1:0]       row_idx;
  logic [COLS-1:0]     capture [ROWS];
  logic [DEBOUNCE-1:0] hist    [ROWS];
  logic [ROWS-1:0]     deb;
  logic                any_r, any_q;
  int unsigned         down_cnt, zero_cnt;
  logic [RW-1:0]       sel_row;
  logic [CLW-1:0]      sel_col;
  logic                key_valid, push_evt;
  logic [CW-1:0]       key_code, fifo_head;
  logic [AW:0]         fifo_count;
  logic                fifo_full, fifo_empty, fifo_ovf;
  logic                tick;

  assign tick = &prescaler;

  // Two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_sense;
      col_s2 <= col_s1;
    end
  end

  // Prescaler, per-row capture/history on each tick, then advance the one-cold strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      row_idx   <= '0;
      row_drive <= ~ROWS'(1);
      for (int unsigned r = 0; r < ROWS; r++) begin
        capture[r] <= '0;
        hist[r]    <= '0;
      end
    end else begin
      prescaler <= prescaler + 1'b1;
      if (tick) begin
        capture[row_idx] <= col_s2;
        hist[row_idx]    <= {hist[row_idx][DEBOUNCE-2:0], ~&col_s2};
        row_drive        <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
        row_idx          <= (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;
      end
    end
  end

  // Per-row debounced state: flips only on a unanimous history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
    end else begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (&hist[r])       deb[r] <= 1'b1;
        else if (~|hist[r]) deb[r] <= 1'b0;
      end
    end
  end

  // Any-key-down registered, then delayed once more to find its rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_r <= 1'b0;
      any_q <= 1'b0;
    end else begin
      any_r <= |deb;
      any_q <= any_r;
    end
  end

  // Locate the pressed row and column, counting rows down and zeros in its capture
  always_comb begin
    down_cnt = 0;
    zero_cnt = 0;
    sel_row  = '0;
    sel_col  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (deb[r]) begin
        down_cnt++;
        sel_row = RW'(r);
      end
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!capture[sel_row][c]) begin
        zero_cnt++;
        sel_col = CLW'(c);
      end
    end
  end

  assign key_valid = (down_cnt == 1) && (zero_cnt == 1);
  assign push_evt  = any_r & ~any_q & key_valid;

  if (MAP_HEX != 0) begin : g_hex
    if (ROWS != 4 || COLS != 4) begin : g_bad_size
      $error("keypad_scan_fifo: MAP_HEX=1 requires a 4x4 matrix");
    end
    assign key_code = CW'(hex_legend(2'(sel_row), 2'(sel_col)));
  end else begin : g_linear
    assign key_code = CW'(int'(sel_row) * COLS + int'(sel_col));
  end

  sync_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_evt),
    .pop     (bus.pop),
    .clr_ovf (bus.clr_ovf),
    .din     (key_code),
    .dout    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .ovf     (fifo_ovf)
  );

  assign bus.irq = ~fifo_empty;

  // Read mux: status word or zero-extended queue head
  always_comb begin
    bus.rdata = '0;
    if (bus.sel_status) begin
      bus.rdata[ST_COUNT_LSB +: 8] = 8'(fifo_count);
      bus.rdata[ST_FULL]           = fifo_full;
      bus.rdata[ST_OVF]            = fifo_ovf;
      bus.rdata[ST_READY]          = ~fifo_empty;
    end else begin
      bus.rdata[CW-1:0] = fifo_head;
    end
  end
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench: stimulus queues expected key codes, a monitor checks every pop.
module tb_keypad_scan_fifo;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TICK  = 4;   // clocks per scan tick with SCAN_DIV = 2
  localparam int unsigned HOLD  = 40;  // ticks a key is held or released

  logic clk = 1'b0;
  logic rst_n;
  logic [ROWS-1:0] row_drive, row_drive2;
  logic [COLS-1:0] col_sense, col_sense2;
  logic [ROWS-1:0][COLS-1:0] keys, keys2;

  keypad_scan_fifo_if bus ();
  keypad_scan_fifo_if bus2 ();

  always #5 clk = ~clk;

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(2), .DEBOUNCE(3),
                     .FIFO_DEPTH(DEPTH), .MAP_HEX(1)) dut (
    .clk(clk), .rst_n(rst_n), .row_drive(row_drive), .col_sense(col_sense), .bus(bus));

  keypad_scan_fifo #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(2), .DEBOUNCE(3),
                     .FIFO_DEPTH(DEPTH), .MAP_HEX(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .row_drive(row_drive2), .col_sense(col_sense2), .bus(bus2));

  // Passive key matrix: a closed key pulls its column low while its row is driven
  always_comb begin
    col_sense  = '1;
    col_sense2 = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!row_drive[r]  && keys[r][c])  col_sense[c]  = 1'b0;
        if (!row_drive2[r] && keys2[r][c]) col_sense2[c] = 1'b0;
      end
  end

  // Reference model: printed legend, a bounded queue and a sticky overflow flag
  int unsigned LEG [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int unsigned exp_q[$];
  bit          m_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_key(input int unsigned r, input int unsigned c, input bit with_pop);
    if (with_pop || exp_q.size() < DEPTH) exp_q.push_back(LEG[r*COLS + c]);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [15:0] exp_status();
    return {8'(exp_q.size()), 5'b0, (exp_q.size() == DEPTH), m_ovf, (exp_q.size() != 0)};
  endfunction

  // Monitor: every CPU pop in data mode must present the oldest queued code
  always @(negedge clk) begin
    if (rst_n && bus.pop && !bus.sel_status) begin
      if (exp_q.size() > 0) begin
        check("pop_irq", 32'(bus.irq), 32'd1);
        check("pop_data", 32'(bus.rdata), 32'(exp_q.pop_front()));
      end else begin
        check("pop_empty_data", 32'(bus.rdata), 32'd0);
      end
    end
  end

  task automatic wait_ticks(input int unsigned n);
    repeat (n * TICK) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int unsigned r, input int unsigned c, input bit multi);
    keys[r][c] = 1'b1;
    if (multi) keys[r][(c + 1) % COLS] = 1'b1;
    wait_ticks(HOLD);
    if (!multi) model_key(r, c, 1'b0);
    keys = '0;
    wait_ticks(HOLD);
  endtask

  task automatic do_pop();
    @(posedge clk); #1;
    bus.sel_status = 1'b0;
    bus.pop        = 1'b1;
    @(posedge clk); #1;
    bus.pop        = 1'b0;
  endtask

  task automatic check_status(input string name);
    bus.sel_status = 1'b1;
    @(negedge clk);
    check(name, 32'(bus.rdata), 32'(exp_status()));
  endtask

  task automatic check_head(input string name);
    bus.sel_status = 1'b0;
    @(negedge clk);
    check(name, 32'(bus.rdata), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    keys  = '0;
    keys2 = '0;
    bus.sel_status  = 1'b1;
    bus.pop         = 1'b0;
    bus.clr_ovf     = 1'b0;
    bus2.sel_status = 1'b0;
    bus2.pop        = 1'b0;
    bus2.clr_ovf    = 1'b0;
    m_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: asynchronous reset while a key is held and a code is queued
    keys[1][2] = 1'b1;
    wait_ticks(HOLD);
    wait_ticks(1);
    bus.sel_status = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_row_drive", 32'(row_drive), 32'h0000_000E);
    check("rst_status", 32'(bus.rdata), 32'h0000_0000);
    check("rst_irq", 32'(bus.irq), 32'd0);
    keys = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;

    // 2: single key row1/col2, then release
    keys[1][2] = 1'b1;
    wait_ticks(HOLD);
    model_key(1, 2, 1'b0);
    check_status("t2_status");
    check_head("t2_head");
    keys = '0;
    wait_ticks(HOLD);
    check_status("t2_release");
    do_pop();
    check_status("t2_after_pop");

    // 3: glitch on row0/col0 shorter than the debounce window
    keys[0][0] = 1'b1;
    wait_ticks(7);
    keys = '0;
    wait_ticks(HOLD);
    check_status("t3_glitch");

    // 4: two keys in one row rejected, then a clean key accepted
    press_release(2, 0, 1'b1);
    check_status("t4_multi");
    press_release(2, 3, 1'b0);
    check_status("t4_single");
    do_pop();

    // 5: five keys into a four-entry queue
    for (int unsigned i = 0; i < 5; i++) press_release(i / 4, i % 4, 1'b0);
    check_status("t5_full_ovf");
    repeat (4) do_pop();
    check_status("t5_drained");
    @(posedge clk); #1 bus.clr_ovf = 1'b1;
    @(posedge clk); #1 bus.clr_ovf = 1'b0;
    m_ovf = 1'b0;
    check_status("t5_clr_ovf");
    do_pop();
    check_status("t5_empty_pop");

    // 6: push and pop in the same clock on a full queue
    for (int unsigned i = 0; i < 4; i++) press_release($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    check_status("t6_full");
    keys[3][2] = 1'b1;
    found = 1'b0;
    for (int unsigned n = 0; n < 60 * TICK && !found; n++) begin
      @(posedge clk); #1;
      if (dut.push_evt) begin
        found = 1'b1;
        model_key(3, 2, 1'b1);
        bus.sel_status = 1'b0;
        bus.pop        = 1'b1;
        @(posedge clk); #1;
        bus.pop        = 1'b0;
      end
    end
    check("t6_event_seen", 32'(found), 32'd1);
    keys = '0;
    wait_ticks(HOLD);
    check_status("t6_status");
    check_head("t6_head");
    while (exp_q.size() > 0) do_pop();
    check_status("t6_drained");

    // Randomised keys with occasional same-row double presses and random pops
    for (int unsigned it = 0; it < 10; it++) begin
      press_release($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) do_pop();
      check_status("rnd_status");
    end
    while (exp_q.size() > 0) do_pop();
    check_status("rnd_drained");

    // Linear code mapping on the second instance: row3/col1 -> 3*COLS+1
    keys2[3][1] = 1'b1;
    wait_ticks(HOLD);
    @(negedge clk);
    check("lin_data", 32'(bus2.rdata), 32'(3 * COLS + 1));
    check("lin_irq", 32'(bus2.irq), 32'd1);
    keys2 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
